// File: rtl/wb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_arbiter_pkg
// Brief    : Shared Wishbone widths, arbiter state encoding and watchdog
//            defaults for the two-master system bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_bus_arbiter_pkg;

  // Bus geometry shared with the top-level memory-map decode
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Watchdog defaults: stall cycles before an error, and counter width
  localparam int TIMEOUT_DEFAULT = 1023;
  localparam int TO_W_DEFAULT    = 10;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_bus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_watchdog
// Brief    : Stall counter for the shared bus. Fires for one cycle when a
//            strobed transfer has gone TIMEOUT cycles without an ack.
// Revision : 1.0 - initial release
// ============================================================================
module wb_watchdog
  import wb_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TO_W    = TO_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic fire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // The last stalled cycle before the limit raises the error; count_en
  // already excludes ack, so a same-cycle ack suppresses the error.
  assign fire = count_en && (cnt_q == LIMIT);

  // Next count: restart after firing or on clear, otherwise count stalls
  always_comb begin
    cnt_d = cnt_q;
    if (clear || fire) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_arbiter
// Brief    : Two-master Wishbone arbiter. Round-robin grant held for a whole
//            CYC, registered grant, combinational bus routing and return
//            gating, and a stall watchdog that errors the owning master.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TO_W    = TO_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  // master 0
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  // master 1
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  // shared bus
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  // status
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  arb_state_t state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       own0, own1;
  logic       wd_fire;

  // State and last-owner registers; last_owner resets to 1 so master 0
  // wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state: grant on CYC only, hold for the whole cycle, and always pass
  // through IDLE between owners.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        end else if (m0_cyc_i) begin
          state_d = ST_OWN0;
        end else if (m1_cyc_i) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign own0    = (state_q == ST_OWN0);
  assign own1    = (state_q == ST_OWN1);
  assign grant_o = {own1, own0};

  // Forward the owner's request onto the shared bus; idle bus is all zero
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Return path: only the owner ever sees ack, error or read data
  assign m0_ack_o  = s_ack_i & own0;
  assign m1_ack_o  = s_ack_i & own1;
  assign m0_dat_o  = own0 ? s_dat_i : '0;
  assign m1_dat_o  = own1 ? s_dat_i : '0;
  assign m0_err_o  = wd_fire & own0;
  assign m1_err_o  = wd_fire & own1;
  assign timeout_o = wd_fire;

  // Stalls count while a strobe waits; dropping CYC (leaving ownership or
  // idling) and any ack restart the count.
  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .count_en (s_cyc_o & s_stb_o & ~s_ack_i),
    .clear    (s_ack_i | ~s_cyc_o),
    .fire     (wd_fire)
  );

endmodule
`default_nettype wire

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master Wishbone arbiter sharing the single system bus (SPI RAM/ROM, UART, GPIO, SPI peripherals) between the wb_oisc core (master 0) and a second master such as a debug loader or DMA (master 1).
- Round-robin grant, locked for a whole master cycle (CYC high).
- Watchdog aborts stalled transfers with a one-cycle error to the owning master.
- Output bus feeds the existing address-bit decode and ack/data mux unchanged.

Parameters:
- TIMEOUT, 1023, stall cycles without ack before the error is raised (1..2^TO_W-1).
- TO_W, 10, width of the watchdog counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control.
- m0_sel_i  in  4  master 0 byte select.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and timeout error.
- m0_dat_o  out  32  master 0 read data.
- m1_*  (same set of signals as m0_*)  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-bus control.
- s_sel_o  out  4  shared-bus byte select.
- s_adr_o, s_dat_o  out  32 each  shared-bus address and write data.
- s_ack_i  in  1  OR of all slave acks.
- s_dat_i  in  32  muxed slave read data.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous): state IDLE, grant_o=00, last_owner=1 so master 0 wins the first tie, watchdog counter=0.
- Reset values of outputs: every s_* output 0, every m*_ack_o/m*_err_o 0, m*_dat_o 0, timeout_o 0.
- States:
  - IDLE: no grant.
  - OWN0: master 0 owns the bus.
  - OWN1: master 1 owns the bus.
- IDLE transitions:
  - Only m0_cyc_i high -> OWN0.
  - Only m1_cyc_i high -> OWN1.
  - Both high -> the master that is not last_owner.
  - Neither high -> stay IDLE.
- Grant is registered: first bus cycle to a slave is 1 cycle after the request is seen in IDLE.
- OWNx transitions:
  - Stays in OWNx while mx_cyc_i=1, so multi-beat/RMW sequences are not interleaved.
  - mx_cyc_i=0 -> IDLE next cycle and last_owner<=x.
  - This gives one mandatory dead cycle between owners.
- Bus routing in OWNx (combinational from the grant register):
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o = master x inputs.
  - In IDLE, all s_* outputs are 0.
- Return path:
  - mx_ack_o = s_ack_i & grant[x].
  - mx_dat_o = grant[x] ? s_dat_i : 0.
  - The non-owner always sees ack=0, err=0, dat=0.
- Watchdog counter:
  - Increments each cycle in which s_cyc_o & s_stb_o & !s_ack_i.
  - Clears on s_ack_i, on leaving OWNx, and in IDLE.
  - When the counter equals TIMEOUT-1 and s_ack_i=0: mx_err_o=1 and timeout_o=1 for that one cycle, and the counter clears.
  - Grant is kept; the master must drop CYC or retry.
- Simultaneous ack and timeout in the same cycle: ack wins, no error.
- Counter saturation: none; it cannot exceed TIMEOUT-1.
- Owner deasserts CYC while a slave ack arrives: ack is still routed that cycle, then IDLE.
- Reset mid-transfer: bus released immediately, state and outputs as in Reset. Slaves must handle CYC dropping (existing SPI slaves restart on the next cycle).
- STB without CYC from a master is ignored; such a master is never granted.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE, ST_OWN0, ST_OWN1.
  - default TIMEOUT.
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4, shared with top-level memory-map bit defines.
- Sub-module wb_watchdog: counter plus compare, with inputs clk, reset, count_en, clear and output fire.
- Arbiter FSM, bus mux and return gating stay in wb_bus_arbiter.

Test Plan:
- Reset release, then m0 single read at 0x20000000 with the slave acking 2 cycles after STB -> grant_o=01 one cycle after the request; m0_ack_o pulses; m0_dat_o=s_dat_i (0x000000A5); m1_ack_o stays 0.
- m0 and m1 assert CYC in the same cycle after reset -> m0 granted first.
  - m0 drops CYC -> one IDLE cycle (grant_o=00), then grant_o=10.
  - Both request again -> m0 wins (round-robin).
- m1 holds CYC across 3 beats to 0x80000000/4/8 while m0 requests -> m0 is not granted until m1 drops CYC; all 3 acks go to m1 only.
- TIMEOUT=8, m0 STB to 0x10000000 with no slave ack -> m0_err_o and timeout_o are high exactly at the 8th stalled cycle; m0_ack_o=0; the counter restarts.
- TIMEOUT=8, s_ack_i arrives on the 8th stall cycle -> m0_ack_o=1, m0_err_o=0, timeout_o=0.
- reset pulsed mid-transfer while in OWN1 -> all s_* outputs and grant_o are 0 immediately (asynchronous). After release, simultaneous requests grant m0 first.
